kernel_axis_packer: RTL and testbench

//  Upstream of the kernel BRAM. Accepts one KERNEL_WIDTH weight per AXI-Stream beat from the DMA.

---
 rtl/kernel_axis_packer_pkg.sv | 14 +
 rtl/kernel_axis_packer_counter.sv | 38 +++
 rtl/kernel_axis_packer.sv | 151 +++++++++++++++
 tb/tb_kernel_axis_packer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_axis_packer_pkg.sv
// Shared sizing for the kernel packer and its tap counter.
package kernel_axis_packer_pkg;

    localparam int unsigned DEF_KERNEL_WIDTH = 16;
    localparam int unsigned DEF_TAPS         = 9;
    localparam int unsigned DEF_CH_BITS      = 9;
    localparam int unsigned DEF_KER_WORD     = DEF_TAPS * DEF_KERNEL_WIDTH;

    // Tap counter width; must hold TAPS-1.
    localparam int unsigned TAP_CNT_W        = 4;

    typedef logic [TAP_CNT_W-1:0] tap_cnt_t;

endpackage

// File: rtl/kernel_axis_packer_counter.sv
// Generic up-counter with synchronous clear and enable.
module kernel_axis_packer_counter
    import kernel_axis_packer_pkg::*;
#(
    parameter int unsigned BITWIDTH = TAP_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    output logic [BITWIDTH-1:0] count
);

    logic [BITWIDTH-1:0] count_q;
    logic [BITWIDTH-1:0] count_d;

    // Clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + BITWIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/kernel_axis_packer.sv
// Packs TAPS consecutive weights into one kernel word, counts kernels per
// frame, drives tlast on the frame's last kernel and flags framing errors.
module kernel_axis_packer
    import kernel_axis_packer_pkg::*;
#(
    parameter int unsigned KERNEL_WIDTH = DEF_KERNEL_WIDTH,
    parameter int unsigned TAPS         = DEF_TAPS,
    parameter int unsigned CH_BITS      = DEF_CH_BITS
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic [CH_BITS-1:0]           CHANNEL_SIZE,
    input  logic [KERNEL_WIDTH-1:0]      s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [TAPS*KERNEL_WIDTH-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic                         framing_error
);

    localparam int unsigned KER_WORD = TAPS * KERNEL_WIDTH;
    localparam int unsigned ASM_W    = (TAPS - 1) * KERNEL_WIDTH;

    logic [TAP_CNT_W-1:0] tap_cnt;
    logic                 tap_en;
    logic                 tap_clr;

    logic [CH_BITS-1:0]   kernel_cnt_q, kernel_cnt_d;
    logic [CH_BITS-1:0]   ch_size_q,    ch_size_d;
    logic [ASM_W-1:0]     asm_q,        asm_d;
    logic [KER_WORD-1:0]  out_data_q,   out_data_d;
    logic                 out_valid_q,  out_valid_d;
    logic                 out_last_q,   out_last_d;
    logic                 err_q,        err_d;

    logic                 last_tap;
    logic                 frame_start;
    logic [CH_BITS-1:0]   ch_in_eff;
    logic [CH_BITS-1:0]   ch_cur;
    logic                 kernel_last;
    logic                 s_ready_c;
    logic                 accept;
    logic                 tlast_exp;
    logic                 violation;
    logic                 emit;

    // Tap position within the kernel being assembled.
    kernel_axis_packer_counter #(
        .BITWIDTH (TAP_CNT_W)
    ) u_tap_cnt (
        .clk   (clk),
        .rst   (Reset),
        .en    (tap_en),
        .clr   (tap_clr),
        .count (tap_cnt)
    );

    // Handshake, framing expectation and emit decode.
    always_comb begin
        last_tap    = (tap_cnt == TAP_CNT_W'(TAPS - 1));
        frame_start = (tap_cnt == '0) && (kernel_cnt_q == '0);
        ch_in_eff   = (CHANNEL_SIZE == '0) ? CH_BITS'(1) : CHANNEL_SIZE;
        // The first beat of a frame compares against the size being latched.
        ch_cur      = frame_start ? ch_in_eff : ch_size_q;
        kernel_last = (kernel_cnt_q == (ch_cur - CH_BITS'(1)));
        // Only the closing tap needs room in the output register.
        s_ready_c   = !Reset && (!out_valid_q || m_axis_tready || !last_tap);
        accept      = s_axis_tvalid && s_ready_c;
        tlast_exp   = last_tap && kernel_last;
        violation   = accept && (s_axis_tlast != tlast_exp);
        // An early tlast on the closing tap drops the beat; a missing one still emits.
        emit        = accept && last_tap && !(violation && s_axis_tlast);
    end

    // Next-state for assembly, output register, kernel counter and error flag.
    always_comb begin
        asm_d        = asm_q;
        ch_size_d    = ch_size_q;
        kernel_cnt_d = kernel_cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        err_d        = err_q;
        tap_en       = 1'b0;
        tap_clr      = 1'b0;

        if (accept && frame_start) begin
            ch_size_d = ch_in_eff;
        end

        if (out_valid_q && m_axis_tready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (violation || last_tap) begin
                tap_clr = 1'b1;
            end else begin
                tap_en = 1'b1;
                for (int unsigned i = 0; i < TAPS - 1; i++) begin
                    if (tap_cnt == TAP_CNT_W'(i)) begin
                        asm_d[i*KERNEL_WIDTH +: KERNEL_WIDTH] = s_axis_tdata;
                    end
                end
            end
        end

        if (emit) begin
            out_data_d   = {s_axis_tdata, asm_q};
            out_valid_d  = 1'b1;
            out_last_d   = kernel_last;
            kernel_cnt_d = kernel_last ? '0 : (kernel_cnt_q + CH_BITS'(1));
        end

        if (violation) begin
            err_d        = 1'b1;
            kernel_cnt_d = '0;
        end
    end

    // State registers; reset discards any partial or pending kernel.
    always_ff @(posedge clk) begin
        if (Reset) begin
            asm_q        <= '0;
            ch_size_q    <= '0;
            kernel_cnt_q <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            asm_q        <= asm_d;
            ch_size_q    <= ch_size_d;
            kernel_cnt_q <= kernel_cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            err_q        <= err_d;
        end
    end

    assign s_axis_tready = s_ready_c;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign framing_error = err_q;

endmodule

// File: tb/tb_kernel_axis_packer.sv
// Directed bench for kernel_axis_packer: frame table plus hand-written
// stall, reset and random-gap sequences checked against a kernel scoreboard.
module tb_kernel_axis_packer;

    logic         clk;
    logic         Reset;
    logic [8:0]   ch;
    logic [15:0]  s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [143:0] m_data;
    logic         m_valid;
    logic         m_last;
    logic         m_ready;
    logic         err;

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;
    int rx_cnt = 0;
    int cyc = 0;
    int mode = 1;   // m_ready: 0 low, 1 high, 2 random

    typedef struct packed {
        logic [143:0] data;
        logic         last;
    } kexp_t;
    kexp_t sbq[$];

    typedef struct {
        int unsigned ch;
        int unsigned nbeats;
        int unsigned last_at;
        logic [15:0] base;
        bit          rst_first;
        int unsigned exp_k;
        logic [7:0]  last_mask;
        bit          exp_err;
    } vec_t;
    vec_t vt[7];

    kernel_axis_packer dut (
        .clk           (clk),
        .Reset         (Reset),
        .CHANNEL_SIZE  (ch),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid),
        .s_axis_tlast  (s_last),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tlast  (m_last),
        .m_axis_tready (m_ready),
        .framing_error (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [143:0] mk_kernel(input logic [15:0] base);
        logic [143:0] k;
        k = '0;
        for (int i = 0; i < 9; i++) k[i*16 +: 16] = base + 16'(i);
        return k;
    endfunction

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int g;
        g = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        #1;
        while (!s_ready && g < 2000) begin
            stall_cnt++;
            @(negedge clk);
            #1;
            g++;
        end
        if (g >= 2000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=stalled required=accept");
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1;
        chk("rst_s_ready_low", 144'(s_ready), 144'(0));
        @(negedge clk);
        #1;
        chk("rst_m_valid", 144'(m_valid), 144'(0));
        chk("rst_m_data", m_data, 144'(0));
        chk("rst_m_last", 144'(m_last), 144'(0));
        chk("rst_err", 144'(err), 144'(0));
        Reset = 1'b0;
        #1;
        chk("rst_s_ready_high", 144'(s_ready), 144'(1));
        sbq.delete();
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        mode = 1;
        while (sbq.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sbq.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // Output monitor: drives m_ready, checks hold stability and scoreboard order.
    initial begin : monitor
        bit           hold_v;
        logic [143:0] hold_d;
        logic         hold_l;
        kexp_t        e;
        hold_v = 1'b0;
        hold_d = '0;
        hold_l = 1'b0;
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (hold_v) begin
                chk("hold_valid", 144'(m_valid), 144'(1));
                chk("hold_data", m_data, hold_d);
                chk("hold_last", 144'(m_last), 144'(hold_l));
            end
            if (m_valid === 1'b1 && m_ready) begin
                hold_v = 1'b0;
                rx_cnt++;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_kernel actual=%0h required=none", m_data);
                end else begin
                    e = sbq.pop_front();
                    chk("kernel_data", m_data, e.data);
                    chk("kernel_last", 144'(m_last), 144'(e.last));
                end
            end else if (m_valid === 1'b1) begin
                hold_v = 1'b1;
                hold_d = m_data;
                hold_l = m_last;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin : main
        int           rx0;
        int           st0;
        int           cyc0;
        logic [143:0] held;
        kexp_t        e;

        Reset   = 1'b1;
        ch      = 9'd2;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;

        //          ch nbeats last  base      rst  k  mask     err
        vt[0] = '{2, 18, 18, 16'h0001, 1'b1, 2, 8'b0000_0010, 1'b0};
        vt[1] = '{1,  5,  5, 16'h0030, 1'b1, 0, 8'b0000_0000, 1'b1};
        vt[2] = '{1,  9,  9, 16'h0040, 1'b0, 1, 8'b0000_0001, 1'b1};
        vt[3] = '{0,  9,  9, 16'h0050, 1'b1, 1, 8'b0000_0001, 1'b0};
        vt[4] = '{1,  9,  0, 16'h0060, 1'b1, 1, 8'b0000_0001, 1'b1};
        vt[5] = '{1,  9,  9, 16'h0080, 1'b0, 1, 8'b0000_0001, 1'b1};
        vt[6] = '{3, 27, 27, 16'h0070, 1'b1, 3, 8'b0000_0100, 1'b0};

        // Frame table with m_ready held high.
        for (int i = 0; i < 7; i++) begin
            if (vt[i].rst_first) do_reset();
            mode = 1;
            ch = 9'(vt[i].ch);
            for (int k = 0; k < int'(vt[i].exp_k); k++) begin
                e.data = mk_kernel(vt[i].base + 16'(9 * k));
                e.last = vt[i].last_mask[k];
                sbq.push_back(e);
            end
            rx0 = rx_cnt;
            st0 = stall_cnt;
            for (int b = 1; b <= int'(vt[i].nbeats); b++)
                send(vt[i].base + 16'(b - 1), 1'(b == int'(vt[i].last_at)));
            wait_drain();
            chk($sformatf("vec%0d_kernels", i), 144'(rx_cnt - rx0), 144'(vt[i].exp_k));
            chk($sformatf("vec%0d_err", i), 144'(err), 144'(vt[i].exp_err));
            chk($sformatf("vec%0d_no_stall", i), 144'(stall_cnt - st0), 144'(0));
        end

        // Output backpressure: closing tap stalls, pending word holds, then same-edge reload.
        do_reset();
        ch = 9'd2;
        mode = 0;
        e.data = mk_kernel(16'h0001); e.last = 1'b0; sbq.push_back(e);
        e.data = mk_kernel(16'h000A); e.last = 1'b1; sbq.push_back(e);
        for (int b = 1; b <= 8; b++) send(16'(b), 1'b0);
        #1;
        chk("lat_before_9th", 144'(m_valid), 144'(0));
        send(16'd9, 1'b0);
        #1;
        chk("lat_after_9th", 144'(m_valid), 144'(1));
        chk("k0_data", m_data, mk_kernel(16'h0001));
        held = m_data;
        st0 = stall_cnt;
        for (int b = 10; b <= 17; b++) send(16'(b), 1'b0);
        chk("bp_taps_accepted", 144'(stall_cnt - st0), 144'(0));
        s_valid = 1'b1;
        s_data  = 16'd18;
        s_last  = 1'b1;
        #1;
        chk("bp_closing_stall", 144'(s_ready), 144'(0));
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("bp_hold_ready", 144'(s_ready), 144'(0));
            chk("bp_hold_data", m_data, held);
        end
        mode = 1;
        send(16'd18, 1'b1);
        #1;
        chk("bp_k1_valid", 144'(m_valid), 144'(1));
        chk("bp_k1_data", m_data, mk_kernel(16'h000A));
        chk("bp_k1_last", 144'(m_last), 144'(1));
        wait_drain();
        chk("bp_err", 144'(err), 144'(0));

        // Reset mid-kernel leaves no residue.
        do_reset();
        ch = 9'd1;
        for (int b = 0; b < 4; b++) send(16'h0011 + 16'(b), 1'b0);
        do_reset();
        e.data = mk_kernel(16'h00A0); e.last = 1'b1; sbq.push_back(e);
        rx0 = rx_cnt;
        for (int b = 0; b < 9; b++) send(16'h00A0 + 16'(b), 1'(b == 8));
        wait_drain();
        chk("rst_mid_kernels", 144'(rx_cnt - rx0), 144'(1));
        chk("rst_mid_err", 144'(err), 144'(0));

        // Random gaps on both sides over 100 kernels, frame of 7.
        do_reset();
        ch = 9'd7;
        for (int n = 0; n < 100; n++) begin
            e.data = mk_kernel(16'h0100 + 16'(n * 9));
            e.last = 1'((n % 7) == 6);
            sbq.push_back(e);
        end
        mode = 2;
        rx0 = rx_cnt;
        for (int n = 0; n < 100; n++) begin
            for (int t = 0; t < 9; t++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
                send(16'h0100 + 16'(n * 9 + t), 1'(t == 8 && (n % 7) == 6));
            end
        end
        wait_drain();
        chk("rand_kernels", 144'(rx_cnt - rx0), 144'(100));
        chk("rand_err", 144'(err), 144'(0));

        // Sustained throughput with both sides held high.
        do_reset();
        ch = 9'd7;
        mode = 1;
        for (int n = 0; n < 7; n++) begin
            e.data = mk_kernel(16'h0800 + 16'(n * 9));
            e.last = 1'(n == 6);
            sbq.push_back(e);
        end
        @(negedge clk);
        cyc0 = cyc;
        st0 = stall_cnt;
        for (int b = 0; b < 63; b++) send(16'h0800 + 16'(b), 1'(b == 62));
        chk("tput_cycles", 144'(cyc - cyc0), 144'(63));
        chk("tput_no_stall", 144'(stall_cnt - st0), 144'(0));
        wait_drain();
        chk("tput_err", 144'(err), 144'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
